// File: rtl/inv_sub_byte_iter.sv
// -----------------------------------------------------------------------------
// inv_sub_byte_iter
//
// Iterative AES InvSubBytes engine for the decryption datapath. A 128-bit state
// is accepted, then LANES bytes per clock are passed through the inverse S-box
// until all 16 bytes have been substituted exactly once. The result is then
// offered downstream and held until taken.
//
// Parameters
//   LANES      inverse S-box instances (bytes per cycle): 1, 2, 4, 8 or 16.
//              A state needs P = 16/LANES BUSY cycles.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   in_data is valid this cycle
//   in_ready   block can accept a state this cycle (IDLE only)
//   in_data    input state, byte k = bits [8k:8k+7], byte 0 = MSB
//   out_valid  out_data holds a completed result (DONE only)
//   out_ready  downstream accepts out_data this cycle
//   out_data   InvSubBytes(in_data), same byte ordering
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. in_ready and out_valid are decoded from the state register only, so
// neither depends combinationally on any input, and they are never both high.
// Once out_valid is high it stays high with out_data stable until out_ready.
// -----------------------------------------------------------------------------
module inv_sub_byte_iter #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data
);

  localparam int P  = 16 / LANES;
  localparam int CW = (P > 1) ? $clog2(P) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [0:127]  st, st_nxt;
  logic [0:127]  st_sub;

  // st with the bytes of the current pass (cnt*LANES .. cnt*LANES+LANES-1)
  // replaced by their inverse S-box value; every other byte passes through.
  // With a single pass the base is forced to 0 so the counter bit is unused.
  always_comb begin
    int base;
    st_sub = st;
    base   = (P == 1) ? 0 : int'(cnt) * LANES;
    for (int l = 0; l < LANES; l++) begin
      st_sub[8*(base+l) +: 8] = INV_SBOX[st[8*(base+l) +: 8]];
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    st_nxt    = st;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          st_nxt    = in_data;
          cnt_nxt   = '0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        st_nxt = st_sub;
        if (cnt == CW'(P - 1)) begin
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      st    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      st    <= st_nxt;
    end
  end

  assign out_data = st;

endmodule

// File: tb/tb_inv_sub_byte_iter.sv
// -----------------------------------------------------------------------------
// tb_inv_sub_byte_iter
//
// Bench for inv_sub_byte_iter. One LANES=4 instance takes directed traffic
// (reset, known vector, corner bytes, back-pressure, back-to-back, reset in
// BUSY) with a scoreboard fed at input handshakes and drained at output
// handshakes. Five more instances (LANES=1,2,4,8,16) each take 1000 random
// states pushed through a forward S-box model and must return the original.
// -----------------------------------------------------------------------------
module tb_inv_sub_byte_iter;

  localparam logic [7:0] FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic rst_rt;
  always #5 clk = ~clk;

  // ---------------- directed DUT (LANES=4) ----------------
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [0:127] in_data, out_data;

  inv_sub_byte_iter #(.LANES(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [7:0] inv_tab [256];

  function automatic logic [127:0] fwd128(input logic [127:0] v);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = FWD[v[127-8*k -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] inv128(input logic [127:0] v);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = inv_tab[v[127-8*k -: 8]];
    return r;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [127:0] exp_q[$];
  int           out_times[$];
  int           cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      check("rdy_vld_excl", 128'(in_ready & out_valid), 128'd0);
      if (in_valid && in_ready) exp_q.push_back(inv128(in_data));
      if (out_valid && out_ready) begin
        out_times.push_back(cyc);
        check("sb_has_entry", 128'(exp_q.size() > 0), 128'd1);
        if (exp_q.size() > 0) check("sb_data", out_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_wait(input logic [127:0] x, output logic [127:0] got, output int lat);
    int g;
    g = 0;
    while (!in_ready && g < 100) begin @(posedge clk); #1; g++; end
    check("in_ready_wait", 128'(in_ready), 128'd1);
    in_data  = x;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    check("out_valid_up", 128'(out_valid), 128'd1);
    got       = out_data;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- round-trip instances ----------------
  for (genvar gi = 0; gi < 5; gi++) begin : g_rt
    localparam int L = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 4 : (gi == 3) ? 8 : 16;
    localparam int P = 16 / L;
    logic         iv, ir, ov, orr, fin;
    logic [0:127] id, od;

    inv_sub_byte_iter #(.LANES(L)) u_rt (
      .clk       (clk),
      .rst       (rst_rt),
      .in_valid  (iv),
      .in_ready  (ir),
      .in_data   (id),
      .out_valid (ov),
      .out_ready (orr),
      .out_data  (od)
    );

    initial begin
      logic [127:0] x;
      logic [127:0] q[$];
      int           lat, g;
      string        tag_d, tag_l;
      tag_d = $sformatf("rt_data_L%0d", L);
      tag_l = $sformatf("rt_lat_L%0d", L);
      fin = 1'b0; iv = 1'b0; orr = 1'b0; id = '0;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 1000; i++) begin
        x = rand128();
        g = 0;
        while (!ir && g < 50) begin @(posedge clk); #1; g++; end
        q.push_back(x);
        id = fwd128(x);
        iv = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        lat = 0;
        while (!ov && lat < 50) begin @(posedge clk); #1; lat++; end
        check(tag_l, 128'(lat), 128'(P));
        check(tag_d, od, q.pop_front());
        orr = 1'b1;
        @(posedge clk); #1;
        orr = 1'b0;
      end
      fin = 1'b1;
    end
  end

  wire all_fin = g_rt[0].fin & g_rt[1].fin & g_rt[2].fin & g_rt[3].fin & g_rt[4].fin;

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] got, x, exp;
    int           lat, g, sent;

    for (int v = 0; v < 256; v++) inv_tab[FWD[v]] = 8'(v);
    rst = 1'b1; rst_rt = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #1;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_data", out_data, 128'd0);
    #11;
    rst = 1'b0; rst_rt = 1'b0;
    @(posedge clk); #1;

    // known vector and latency
    send_wait(128'h637c777bf26b6fc53001672bfed7ab76, got, lat);
    check("kv_data", got, 128'h000102030405060708090a0b0c0d0e0f);
    check("kv_latency", 128'(lat), 128'd4);

    // corner bytes
    send_wait({16{8'h63}}, got, lat);
    check("corner_63", got, {16{8'h00}});
    send_wait({16{8'h16}}, got, lat);
    check("corner_16", got, {16{8'hff}});
    send_wait({16{8'hed}}, got, lat);
    check("corner_ed", got, {16{8'h53}});

    // a few random states, checked through the scoreboard
    for (int i = 0; i < 4; i++) begin
      send_wait(rand128(), got, lat);
      check("rand_latency", 128'(lat), 128'd4);
    end

    // back-pressure in DONE while in_valid toggles with fresh data
    x = rand128();
    exp = inv128(x);
    in_data = x; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    g = 0;
    while (!out_valid && g < 50) begin @(posedge clk); #1; g++; end
    check("bp_valid_up", 128'(out_valid), 128'd1);
    for (int i = 0; i < 20; i++) begin
      in_valid = ~in_valid;
      in_data  = rand128();
      @(posedge clk); #1;
      check("bp_hold_data", out_data, exp);
      check("bp_in_ready_low", 128'(in_ready), 128'd0);
      check("bp_out_valid_high", 128'(out_valid), 128'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_in_ready", 128'(in_ready), 128'd1);
    check("bp_release_out_valid", 128'(out_valid), 128'd0);

    // back-to-back: one result every 6 cycles
    out_times.delete();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = rand128();
    sent = 0; g = 0;
    while (sent < 12 && g < 500) begin
      @(negedge clk); g++;
      if (in_ready) begin
        sent++;
        @(posedge clk); #1;
        if (sent < 12) in_data = rand128();
        else in_valid = 1'b0;
      end
    end
    g = 0;
    while (out_times.size() < 12 && g < 100) begin @(posedge clk); g++; end
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("b2b_count", 128'(out_times.size()), 128'd12);
    for (int i = 1; i < out_times.size(); i++)
      check("b2b_gap", 128'(out_times[i] - out_times[i-1]), 128'd6);
    check("b2b_drained", 128'(exp_q.size()), 128'd0);

    // asynchronous reset in the middle of BUSY
    @(posedge clk); #1;
    in_data = rand128(); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_in_ready", 128'(in_ready), 128'd1);
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_out_data", out_data, 128'd0);
    x = rand128();
    in_data = x; in_valid = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("midrst_first_accept", 128'(in_ready), 128'd0);
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    check("midrst_latency", 128'(lat), 128'd4);
    check("midrst_data", out_data, inv128(x));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("midrst_drained", 128'(exp_q.size()), 128'd0);

    // wait for the round-trip instances
    g = 0;
    while (!all_fin && g < 30000) begin @(posedge clk); g++; end
    check("rt_all_finished", 128'(all_fin), 128'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inv_sub_byte_iter.md
# inv_sub_byte_iter

Iterative AES InvSubBytes engine for the decryption datapath. It is the inverse of the combinational forward SubBytes stage. It accepts a 128-bit state over a valid/ready handshake and applies the FIPS-197 inverse S-box to LANES bytes per clock. It returns the substituted state over a second valid/ready handshake, trading latency for a fraction of the S-box area of a fully parallel stage.

## Interface
- LANES, default 4: inverse S-box instances, i.e. bytes processed per cycle. Legal values: 1, 2, 4, 8, 16. Pass count P = 16/LANES.
- clk  input  1  rising-edge clock; the only clock in the block
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  block can accept a state this cycle
- in_data  input  [0:127]  ciphertext-side state; byte k = bits [8k:8k+7], byte 0 = MSB
- out_valid  output  1  out_data holds a completed result
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  [0:127]  InvSubBytes(in_data), same byte ordering

## Operation
- State register st[0:127], pass counter cnt (width clog2(P), minimum 1 bit), FSM with states IDLE, BUSY, DONE.
- IDLE: in_ready=1, out_valid=0.
  - On in_valid&&in_ready: st<=in_data, cnt<=0, next state BUSY.
  - Otherwise remain in IDLE.
- BUSY: in_ready=0, out_valid=0.
  - Each cycle, bytes cnt*LANES .. cnt*LANES+LANES-1 of st are replaced by InvSbox(byte). All other bytes are held.
  - cnt<=cnt+1. When cnt==P-1, next state is DONE and cnt wraps to 0.
- DONE: out_valid=1, in_ready=0, out_data=st.
  - On out_ready: next state IDLE.
  - Otherwise hold; st and out_data stay stable.
- out_data is driven from st in every state. It is meaningful only while out_valid=1.
- InvSbox is the FIPS-197 inverse table, with the same byte mapping as the forward sbox inverted: InvSbox(Sbox(x))=x for all 256 x. Each lane is a pure function of 8 bits.
- in_valid asserted while in BUSY or DONE is ignored. Upstream must hold the data until in_ready=1.
- Each byte is substituted exactly once per accepted state. No byte is skipped or double-substituted.

## Timing
- Reset (async assert, any state): FSM=IDLE, cnt=0, st=0. Consequently in_ready=1, out_valid=0, out_data=0 immediately, without waiting for a clock edge.
- Reset release: the first acceptance may occur on the first rising edge after deassertion.
- Reset mid-BUSY or mid-DONE: the in-flight state is discarded and no output is produced.
- Latency: state accepted on edge E. BUSY occupies edges E+1..E+P. out_valid rises after edge E+P.
  - With LANES=4, out_valid is first high in the 4th cycle after acceptance.
- DONE->IDLE on edge D (out_ready high). in_ready=1 in the following cycle. The next acceptance is possible at the earliest on edge D+1.
- Maximum throughput: one state per P+2 cycles. With LANES=4 that is 6 cycles.
- out_valid, once high, stays high with out_data unchanged until the out_ready handshake completes. Back-pressure of any length is legal.
- in_ready and out_valid are never both 1. in_ready is a pure function of FSM state (registered, no combinational in->out path).
- out_ready is sampled only in DONE. Its value in IDLE or BUSY has no effect.

## Test plan
- Reset: assert rst asynchronously mid-BUSY -> in_ready=1, out_valid=0, out_data=0 immediately; after release, a new state is accepted on the first edge.
- Known vector (LANES=4): in_data=0x637c777bf26b6fc53001672bfed7ab76 -> out_data=0x000102030405060708090a0b0c0d0e0f; out_valid first high 4 cycles after acceptance.
- Corner bytes: in_data = all 0x63 -> all 0x00; all 0x16 -> all 0xff; all 0xed -> all 0x53.
- Round trip: 1000 random X passed through the forward sub_byte, then this block -> out_data==X each time. Repeat for LANES=1, 2, 8, 16 and check latency = 16/LANES.
- Back-pressure: hold out_ready=0 for 20 cycles in DONE while toggling in_valid with new data -> out_data stable, in_ready=0, no new state captured; on out_ready=1, in_ready rises the next cycle.
- Back-to-back: in_valid and out_ready held high continuously -> exactly one result every 6 cycles (LANES=4), in order, none dropped or duplicated.
